m68k_region_decoder: RTL and testbench
======================================

// Module: m68k_region_decoder
// PURPOSE
//  Programmable, registered 68000 address decoder and bus-cycle sequencer.
//  Replaces fixed per-PCB chip-select maps: the top level loads up to REGIONS
//  address windows at boot, one per selected PCB, each with its own wait-state count.
//  For every AS_n cycle it latches a one-hot chip select and produces DTACK_n,
//  or BERR_n after a timeout for unmapped addresses.
//  Sits between the CPU core and the RAM, ROM and IO select fan-out in the core top.
// PARAMETERS
//  ADDR_W        24  CPU address width in bits
//  REGIONS       16  number of decode windows; index 0 has highest priority
//  WAIT_W         3  width of the per-region wait-state count
//  BERR_TIMEOUT  64  clk_sys cycles from an unmapped AS_n to BERR_n assertion
// PORTS
//  clk_sys     in   1                 system clock; all logic on its rising edge
//  reset_n     in   1                 asynchronous, active-low reset
//  cpu_a       in   ADDR_W            CPU byte address; sampled only in IDLE
//  cpu_as_n    in   1                 address strobe, active low, already in the clk_sys domain
//  cfg_we      in   1                 region table write strobe
//  cfg_idx     in   $clog2(REGIONS)   region index to write
//  cfg_base    in   ADDR_W            first address of the window, inclusive
//  cfg_end     in   ADDR_W            last address of the window, inclusive
//  cfg_wait    in   WAIT_W            wait states inserted before DTACK_n
//  cs          out  REGIONS           one-hot registered chip select
//  region_idx  out  $clog2(REGIONS)   index of the active region
//  dtack_n     out  1                 data acknowledge, active low
//  berr_n      out  1                 bus error, active low
//  busy        out  1                 high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE, cs=0, region_idx=0, dtack_n=1, berr_n=1, busy=0.
//   - Every table entry set to base=all-ones, end=0, wait=0; all regions disabled.
//   - Any bus cycle in progress is abandoned; no DTACK_n or BERR_n is issued.
//  Table:
//   - Written on a clk_sys edge with cfg_we=1.
//   - A write with cfg_idx>=REGIONS is ignored.
//   - A region is enabled iff base<=end. Match test: base<=cpu_a<=end, unsigned, full ADDR_W.
//   - Writes during a cycle are allowed and only affect the next decode.
//     The latched cs, region_idx and wait count are never altered mid-cycle.
//  FSM states: IDLE, WAIT, ACK, UNMAP, BERR.
//   - IDLE: on an edge k with cpu_as_n=0, decode cpu_a. Lowest matching index wins.
//     - Hit: cs[i]=1 and region_idx=i after edge k; wait counter loaded with wait[i].
//       Go to ACK if wait=0, otherwise go to WAIT.
//     - Miss: cs stays 0; timeout counter cleared; go to UNMAP.
//   - WAIT: counter decrements once per cycle; move to ACK when it reaches 1.
//     dtack_n goes 0 after edge k+1+W, where W is the region wait count (W=0 gives edge k+1).
//   - ACK: dtack_n=0 and cs held until cpu_as_n is sampled 1.
//   - UNMAP: counter increments each cycle. On reaching BERR_TIMEOUT-1, berr_n=0 and go to BERR.
//   - BERR: berr_n held 0 until cpu_as_n is sampled 1.
//  Cycle end:
//   - cpu_as_n sampled 1 in any non-IDLE state leads to IDLE on that edge.
//   - cs=0, dtack_n=1, berr_n=1 after that edge; region_idx holds its last value.
//   - This includes abort during WAIT or UNMAP: no acknowledge or error is emitted.
//  Back-to-back cycles:
//   - A new decode is only possible from IDLE, so there is at least one idle edge between cycles.
//   - If cpu_as_n is still 0 on the edge after returning to IDLE, that counts as a new cycle.
//  Simultaneity:
//   - A cfg write and a decode on the same edge: the decode uses the table value from before the write.
//   - The timeout counter is wide enough to hold BERR_TIMEOUT without wrapping.
//  Output rules:
//   - cs is always one-hot or zero.
//   - dtack_n and berr_n are never low together.
// TESTING
//  T1: region0=060000..063fff, W=0; AS_n low, a=061234 at edge k
//      -> cs=0x0001 after k; dtack_n=0 after k+1; release AS_n -> all idle next edge.
//  T2: region3=078000..078007, W=3; a=078004
//      -> cs[3]=1, region_idx=3; dtack_n low after exactly k+4.
//  T3: region1=000000..05ffff and region2=040000..07ffff (overlap); a=050000
//      -> cs=0x0002 (lower index wins).
//  T4: unmapped a=0f0000
//      -> cs=0, berr_n low after k+64, dtack_n stays 1.
//      Repeat with AS_n raised at k+10 -> no BERR_n.
//  T5: W=7 cycle, assert reset_n=0 at k+2
//      -> all outputs reach reset values immediately, table cleared; the next cycle misses.
//  T6: rewrite region0 to 100000..10ffff while a region0 cycle waits
//      -> current cycle still acks; next a=061234 misses; cfg_idx=16 write is ignored.

Source files
------------

// File: rtl/m68k_region_decoder_if.sv
// CPU bus and region-table port bundle between the 68000 core top and the region decoder.
// cfg_idx carries one extra bit so indices at or above REGIONS can be presented and rejected.
interface m68k_region_decoder_if #(
  parameter int ADDR_W  = 24,
  parameter int REGIONS = 16,
  parameter int WAIT_W  = 3
);
  localparam int IDX_W     = $clog2(REGIONS);
  localparam int CFG_IDX_W = IDX_W + 1;

  logic [ADDR_W-1:0]    cpu_a;
  logic                 cpu_as_n;
  logic                 cfg_we;
  logic [CFG_IDX_W-1:0] cfg_idx;
  logic [ADDR_W-1:0]    cfg_base;
  logic [ADDR_W-1:0]    cfg_end;
  logic [WAIT_W-1:0]    cfg_wait;
  logic [REGIONS-1:0]   cs;
  logic [IDX_W-1:0]     region_idx;
  logic                 dtack_n;
  logic                 berr_n;
  logic                 busy;

  modport master (
    output cpu_a, cpu_as_n, cfg_we, cfg_idx, cfg_base, cfg_end, cfg_wait,
    input  cs, region_idx, dtack_n, berr_n, busy
  );

  modport slave (
    input  cpu_a, cpu_as_n, cfg_we, cfg_idx, cfg_base, cfg_end, cfg_wait,
    output cs, region_idx, dtack_n, berr_n, busy
  );
endinterface

// File: rtl/m68k_region_decoder.sv
// Programmable 68000 address decoder: registered one-hot chip select per AS_n cycle, DTACK_n after
// the region's wait states (edge k+1+W), BERR_n BERR_TIMEOUT edges after an unmapped strobe.
module m68k_region_decoder #(
  parameter int ADDR_W       = 24,
  parameter int REGIONS      = 16,
  parameter int WAIT_W       = 3,
  parameter int BERR_TIMEOUT = 64
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  m68k_region_decoder_if.slave   bus
);
  localparam int IDX_W     = $clog2(REGIONS);
  localparam int CFG_IDX_W = IDX_W + 1;
  localparam int TO_W      = $clog2(BERR_TIMEOUT + 1);
  localparam logic [CFG_IDX_W-1:0] NUM_REGIONS = CFG_IDX_W'(REGIONS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_UNMAP,
    S_BERR
  } state_t;

  logic [ADDR_W-1:0] base_q [REGIONS];
  logic [ADDR_W-1:0] end_q  [REGIONS];
  logic [WAIT_W-1:0] wait_q [REGIONS];

  state_t             state_q, state_d;
  logic [REGIONS-1:0] cs_q, cs_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WAIT_W-1:0]  wcnt_q, wcnt_d;
  logic [TO_W-1:0]    tcnt_q, tcnt_d;
  logic               dtack_n_q, dtack_n_d;
  logic               berr_n_q, berr_n_d;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;

  // Reset value base=all-ones, end=0 leaves every window empty, so no enable bit is needed.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REGIONS; i++) begin
        base_q[i] <= '1;
        end_q[i]  <= '0;
        wait_q[i] <= '0;
      end
    end else if (bus.cfg_we && (bus.cfg_idx < NUM_REGIONS)) begin
      base_q[bus.cfg_idx[IDX_W-1:0]] <= bus.cfg_base;
      end_q[bus.cfg_idx[IDX_W-1:0]]  <= bus.cfg_end;
      wait_q[bus.cfg_idx[IDX_W-1:0]] <= bus.cfg_wait;
    end
  end

  // Descending scan: the last assignment is the lowest matching index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = REGIONS - 1; i >= 0; i--) begin
      if ((base_q[i] <= bus.cpu_a) && (bus.cpu_a <= end_q[i])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cs_q      <= '0;
      idx_q     <= '0;
      wcnt_q    <= '0;
      tcnt_q    <= '0;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cs_q      <= cs_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      tcnt_q    <= tcnt_d;
      dtack_n_q <= dtack_n_d;
      berr_n_q  <= berr_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cs_d      = cs_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    tcnt_d    = tcnt_q;
    dtack_n_d = dtack_n_q;
    berr_n_d  = berr_n_q;

    if (state_q == S_IDLE) begin
      if (!bus.cpu_as_n) begin
        if (hit) begin
          cs_d    = {{(REGIONS-1){1'b0}}, 1'b1} << hit_idx;
          idx_d   = hit_idx;
          wcnt_d  = wait_q[hit_idx];
          state_d = (wait_q[hit_idx] == '0) ? S_ACK : S_WAIT;
        end else begin
          tcnt_d  = '0;
          state_d = S_UNMAP;
        end
      end
    end else if (bus.cpu_as_n) begin
      // Strobe released: end the cycle, including aborts before any acknowledge.
      state_d   = S_IDLE;
      cs_d      = '0;
      dtack_n_d = 1'b1;
      berr_n_d  = 1'b1;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (wcnt_q == WAIT_W'(1)) state_d = S_ACK;
          else                      wcnt_d  = wcnt_q - WAIT_W'(1);
        end
        S_ACK:   dtack_n_d = 1'b0;
        S_UNMAP: begin
          if (tcnt_q == TO_W'(BERR_TIMEOUT - 1)) begin
            berr_n_d = 1'b0;
            state_d  = S_BERR;
          end else begin
            tcnt_d = tcnt_q + TO_W'(1);
          end
        end
        S_BERR:  berr_n_d = 1'b0;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.cs         = cs_q;
  assign bus.region_idx = idx_q;
  assign bus.dtack_n    = dtack_n_q;
  assign bus.berr_n     = berr_n_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_m68k_region_decoder.sv
// Directed-vector bench for m68k_region_decoder: decode, priority, wait states, timeout, abort, reset, live table rewrite.
module tb_m68k_region_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  m68k_region_decoder_if bus ();

  m68k_region_decoder dut (
    .clk_sys (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input logic [23:0] b, input logic [23:0] e, input logic [2:0] w);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = 5'(idx);
    bus.cfg_base = b;
    bus.cfg_end  = e;
    bus.cfg_wait = w;
    tick;
    bus.cfg_we   = 1'b0;
  endtask

  task automatic start_cycle(input logic [23:0] a);
    bus.cpu_a    = a;
    bus.cpu_as_n = 1'b0;
    tick;
  endtask

  task automatic end_cycle;
    bus.cpu_as_n = 1'b1;
    tick;
  endtask

  // Edges after edge k until dtack_n goes low, bounded.
  task automatic edges_to_dtack(output int n);
    n = 0;
    while (bus.dtack_n === 1'b1 && n < 20) begin
      tick;
      n++;
    end
  endtask

  initial begin
    int n;
    bit seen;
    bus.cpu_a    = '0;
    bus.cpu_as_n = 1'b1;
    bus.cfg_we   = 1'b0;
    bus.cfg_idx  = '0;
    bus.cfg_base = '0;
    bus.cfg_end  = '0;
    bus.cfg_wait = '0;
    #23 rst_n = 1'b1;
    tick;

    chk("rst_cs",    32'(bus.cs), 32'h0);
    chk("rst_idx",   32'(bus.region_idx), 32'h0);
    chk("rst_dtack", 32'(bus.dtack_n), 32'h1);
    chk("rst_berr",  32'(bus.berr_n), 32'h1);
    chk("rst_busy",  32'(bus.busy), 32'h0);

    // T1: zero wait states
    cfg_write(0, 24'h060000, 24'h063fff, 3'd0);
    start_cycle(24'h061234);
    chk("t1_cs_k",    32'(bus.cs), 32'h0001);
    chk("t1_dtack_k", 32'(bus.dtack_n), 32'h1);
    chk("t1_busy_k",  32'(bus.busy), 32'h1);
    tick;
    chk("t1_dtack_k1", 32'(bus.dtack_n), 32'h0);
    chk("t1_berr_k1",  32'(bus.berr_n), 32'h1);
    end_cycle;
    chk("t1_cs_end",    32'(bus.cs), 32'h0);
    chk("t1_dtack_end", 32'(bus.dtack_n), 32'h1);
    chk("t1_busy_end",  32'(bus.busy), 32'h0);

    // T2: three wait states
    cfg_write(3, 24'h078000, 24'h078007, 3'd3);
    start_cycle(24'h078004);
    chk("t2_cs",  32'(bus.cs), 32'h0008);
    chk("t2_idx", 32'(bus.region_idx), 32'h3);
    edges_to_dtack(n);
    chk("t2_dtack_edges", 32'(n), 32'd4);
    chk("t2_cs_ack", 32'(bus.cs), 32'h0008);
    end_cycle;
    chk("t2_idx_hold", 32'(bus.region_idx), 32'h3);

    // T3: overlapping windows, lower index wins
    cfg_write(1, 24'h000000, 24'h05ffff, 3'd0);
    cfg_write(2, 24'h040000, 24'h07ffff, 3'd0);
    start_cycle(24'h050000);
    chk("t3_cs",  32'(bus.cs), 32'h0002);
    chk("t3_idx", 32'(bus.region_idx), 32'h1);
    tick;
    chk("t3_dtack", 32'(bus.dtack_n), 32'h0);
    end_cycle;
    start_cycle(24'h078004);
    chk("t3_cs_r2_over_r3", 32'(bus.cs), 32'h0004);
    end_cycle;

    // T4: unmapped address times out
    start_cycle(24'h0f0000);
    chk("t4_cs",   32'(bus.cs), 32'h0);
    chk("t4_busy", 32'(bus.busy), 32'h1);
    n = 0;
    seen = 1'b0;
    while (bus.berr_n === 1'b1 && n < 100) begin
      tick;
      n++;
      if (bus.dtack_n !== 1'b1) seen = 1'b1;
    end
    chk("t4_berr_edges", 32'(n), 32'd64);
    chk("t4_no_dtack", 32'(seen), 32'h0);
    end_cycle;
    chk("t4_berr_end", 32'(bus.berr_n), 32'h1);
    chk("t4_busy_end", 32'(bus.busy), 32'h0);

    // T4b: abort at k+10 suppresses BERR_n
    start_cycle(24'h0f0000);
    repeat (9) tick;
    end_cycle;
    chk("t4b_busy", 32'(bus.busy), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick;
      if (bus.berr_n !== 1'b1) seen = 1'b1;
    end
    chk("t4b_no_berr", 32'(seen), 32'h0);

    // T5: async reset mid-wait
    cfg_write(4, 24'h200000, 24'h2000ff, 3'd7);
    start_cycle(24'h200010);
    chk("t5_cs", 32'(bus.cs), 32'h0010);
    tick;
    rst_n = 1'b0;
    bus.cpu_as_n = 1'b1;
    #1;
    chk("t5_rst_cs",    32'(bus.cs), 32'h0);
    chk("t5_rst_idx",   32'(bus.region_idx), 32'h0);
    chk("t5_rst_busy",  32'(bus.busy), 32'h0);
    chk("t5_rst_dtack", 32'(bus.dtack_n), 32'h1);
    #3 rst_n = 1'b1;
    tick;
    start_cycle(24'h061234);
    chk("t5_miss_cs",   32'(bus.cs), 32'h0);
    chk("t5_miss_busy", 32'(bus.busy), 32'h1);
    tick;
    chk("t5_miss_dtack", 32'(bus.dtack_n), 32'h1);
    end_cycle;

    // T6: table rewrite while a cycle waits
    cfg_write(0, 24'h060000, 24'h063fff, 3'd5);
    start_cycle(24'h061234);
    chk("t6_cs", 32'(bus.cs), 32'h0001);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = 5'd0;
    bus.cfg_base = 24'h100000;
    bus.cfg_end  = 24'h10ffff;
    bus.cfg_wait = 3'd0;
    n = 0;
    while (bus.dtack_n === 1'b1 && n < 20) begin
      tick;
      bus.cfg_we = 1'b0;
      n++;
    end
    chk("t6_dtack_edges", 32'(n), 32'd6);
    chk("t6_cs_ack", 32'(bus.cs), 32'h0001);
    end_cycle;
    cfg_write(16, 24'h061000, 24'h0612ff, 3'd0);
    start_cycle(24'h061234);
    chk("t6_old_miss_cs",   32'(bus.cs), 32'h0);
    chk("t6_old_miss_busy", 32'(bus.busy), 32'h1);
    end_cycle;
    start_cycle(24'h100010);
    chk("t6_new_cs", 32'(bus.cs), 32'h0001);
    tick;
    chk("t6_new_dtack", 32'(bus.dtack_n), 32'h0);
    end_cycle;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
